pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage. It consumes pcsrc from the branch-compare logic and the branch target, and holds the 16-bit PC.
- Issues word fetches to instruction memory over a req/ready handshake.
- Presents one fetched instruction, with its PC, to decode through a single-entry output register with stall and flush.

---
 rtl/pc_fetch_unit_pkg.sv | 10 +
 rtl/pc_fetch_unit_if.sv | 20 ++
 rtl/pc_next_mux.sv | 12 +
 rtl/pc_fetch_unit.sv | 52 +++++
 tb/tb_pc_fetch_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch-stage widths, reset PC, pcsrc encodings and FSM states
package pc_fetch_unit_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;
  localparam logic [DATA_W-1:0] PC_INC = 16'h0001;
  localparam logic PCSRC_BRANCH = 1'b0;
  localparam logic PCSRC_SEQ = 1'b1;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory handshake plus the fetch-to-decode slot
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;
  logic imem_req;
  word_t imem_addr;
  logic imem_ready;
  word_t imem_rdata;
  logic id_stall;
  word_t instr;
  word_t instr_pc;
  logic instr_valid;
  modport master(
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input imem_ready, imem_rdata, id_stall
  );
  modport slave(
    input imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ready, imem_rdata, id_stall
  );
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: picks branch target, pc+PC_INC or held pc
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic  pcsrc,
  input  logic  accept,
  input  word_t pc,
  input  word_t branch_target,
  output word_t pc_next
);
  always_comb pc_next = pcsrc == PCSRC_BRANCH ? branch_target : accept ? pc + PC_INC : pc;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, imem fetch FSM and single-entry decode output register
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pcsrc,
  input  word_t branch_target,
  pc_fetch_unit_if.master bus
);
  fetch_state_e state, state_nx;
  word_t pc, pc_nx, drain_addr;
  logic redirect, slot_free, req, accept;
  assign redirect = pcsrc == PCSRC_BRANCH;
  assign slot_free = !bus.instr_valid || !bus.id_stall;
  assign req = state == S_DRAIN || (state == S_REQ && slot_free);
  assign accept = state == S_REQ && req && bus.imem_ready && pcsrc == PCSRC_SEQ;
  pc_next_mux u_pc_next_mux (
    .pcsrc(pcsrc),
    .accept(accept),
    .pc(pc),
    .branch_target(branch_target),
    .pc_next(pc_nx)
  );
  always_comb begin
    bus.imem_req = req;
    bus.imem_addr = state == S_DRAIN ? drain_addr : pc;
    state_nx = state == S_IDLE ? S_REQ :
               state == S_REQ ? (redirect && req && !bus.imem_ready ? S_DRAIN : S_REQ) :
               (bus.imem_ready ? S_REQ : S_DRAIN);
  end
  // drain_addr tracks pc until a redirect strands an unanswered request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      drain_addr <= RESET_PC;
      bus.instr <= '0;
      bus.instr_pc <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (state != S_DRAIN) drain_addr <= pc;
      if (redirect) bus.instr_valid <= 1'b0;
      else if (accept) begin
        bus.instr <= bus.imem_rdata;
        bus.instr_pc <= pc;
        bus.instr_valid <= 1'b1;
      end else if (!bus.id_stall) bus.instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus checked against a per-cycle behavioural fetch model
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pcsrc = 1'b1;
  logic stall = 1'b0;
  logic rdy = 1'b0;
  word_t bt = '0;
  int tests = 0;
  int errs = 0;
  word_t m_pc, m_drain_addr, m_instr, m_instr_pc, exp_addr;
  logic m_started, m_drain, m_valid, exp_req;
  pc_fetch_unit_if bus();
  always #5 clk = ~clk;
  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = rdy ? bus.imem_addr ^ 16'hA5A5 : 16'hDEAD;
  assign bus.id_stall = stall;
  pc_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .pcsrc(pcsrc),
    .branch_target(bt),
    .bus(bus)
  );
  task automatic chk(input string n, input word_t a, input word_t e);
    tests++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk1(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic ps, input word_t t, input logic st, input logic rd);
    pcsrc = ps;
    bt = t;
    stall = st;
    rdy = rd;
    @(posedge clk);
    #1;
  endtask
  // Model: one outstanding request, an optional "discard" pending beat, and the decode slot
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = RESET_PC;
      m_drain_addr = RESET_PC;
      m_instr = '0;
      m_instr_pc = '0;
      m_started = 1'b0;
      m_drain = 1'b0;
      m_valid = 1'b0;
      chk1("rst_req", bus.imem_req, 1'b0);
      chk1("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
      chk("rst_instr", bus.instr, 16'h0000);
    end else begin
      exp_req = m_drain || (m_started && (!m_valid || !stall));
      exp_addr = m_drain ? m_drain_addr : m_pc;
      chk1("req", bus.imem_req, exp_req);
      chk("addr", bus.imem_addr, exp_addr);
      chk1("valid", bus.instr_valid, m_valid);
      chk("instr", bus.instr, m_instr);
      chk("instr_pc", bus.instr_pc, m_instr_pc);
      if (pcsrc == PCSRC_BRANCH) begin
        if (m_drain) m_drain = !rdy;
        else if (exp_req && !rdy) begin
          m_drain = 1'b1;
          m_drain_addr = m_pc;
        end
        m_valid = 1'b0;
        m_pc = bt;
      end else if (m_drain) m_drain = !rdy;
      else if (exp_req && rdy) begin
        m_instr = exp_addr ^ 16'hA5A5;
        m_instr_pc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + PC_INC;
      end else if (!stall) m_valid = 1'b0;
      m_started = 1'b1;
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk1("idle_req", bus.imem_req, 1'b0);
    chk1("idle_valid", bus.instr_valid, 1'b0);
    // zero-wait streaming
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("seq_addr0", bus.imem_addr, 16'h0000);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, '0, 1'b0, 1'b1);
      chk("seq_addr", bus.imem_addr, word_t'(i));
      chk("seq_pc", bus.instr_pc, word_t'(i - 1));
      chk1("seq_valid", bus.instr_valid, 1'b1);
    end
    chk("seq_instr", bus.instr, 16'hA5A7);
    // three wait states per beat
    repeat (2) begin
      repeat (3) cyc(1'b1, '0, 1'b0, 1'b0);
      cyc(1'b1, '0, 1'b0, 1'b1);
    end
    chk("wait_pc", bus.instr_pc, 16'h0004);
    chk("wait_addr", bus.imem_addr, 16'h0005);
    // decode stall
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("stall_pc0", bus.instr_pc, 16'h0005);
    repeat (4) begin
      cyc(1'b1, '0, 1'b1, 1'b1);
      chk("stall_pc", bus.instr_pc, 16'h0005);
      chk1("stall_req", bus.imem_req, 1'b0);
      chk1("stall_valid", bus.instr_valid, 1'b1);
    end
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("resume_pc", bus.instr_pc, 16'h0006);
    chk("resume_instr", bus.instr, 16'hA5A3);
    // redirect with an unanswered request
    cyc(1'b1, '0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0040, 1'b0, 1'b0);
    chk1("drain_req", bus.imem_req, 1'b1);
    chk("drain_addr", bus.imem_addr, 16'h0007);
    chk1("drain_flush", bus.instr_valid, 1'b0);
    cyc(1'b1, '0, 1'b0, 1'b0);
    chk("drain_hold", bus.imem_addr, 16'h0007);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("tgt_addr", bus.imem_addr, 16'h0040);
    chk1("tgt_drop", bus.instr_valid, 1'b0);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("tgt_pc", bus.instr_pc, 16'h0040);
    // wrap past 16'hFFFF
    cyc(1'b0, 16'hFFFF, 1'b0, 1'b1);
    chk("wrap_addr", bus.imem_addr, 16'hFFFF);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("wrap_pc0", bus.instr_pc, 16'hFFFF);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("wrap_pc1", bus.instr_pc, 16'h0000);
    // second redirect while draining only moves pc
    cyc(1'b1, '0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0020, 1'b0, 1'b0);
    cyc(1'b0, 16'h0030, 1'b0, 1'b0);
    chk("redrain_addr", bus.imem_addr, 16'h0001);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("redrain_tgt", bus.imem_addr, 16'h0030);
    // asynchronous reset mid-request
    cyc(1'b1, '0, 1'b0, 1'b1);
    rdy = 1'b0;
    #2;
    chk1("pre_rst_req", bus.imem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_req", bus.imem_req, 1'b0);
    chk1("async_valid", bus.instr_valid, 1'b0);
    chk("async_pc", bus.instr_pc, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("restart_addr", bus.imem_addr, RESET_PC);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk("restart_pc", bus.instr_pc, RESET_PC);
    chk1("restart_valid", bus.instr_valid, 1'b1);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
